alu_exception_unit: RTL and testbench

- Consumer end of the ALU status interface; the ALU writes flags, this block reads them.
- Samples the 8-bit ALU status byte each valid execute cycle, accumulates sticky flags and raises precise exception requests (overflow, divide-by-zero, misalignment).
- Latches cause and EPC, then holds the request until the control unit acknowledges it.
- Sits between the ALU and the main control / PC logic of the single-issue MIPS datapath.

---
 rtl/alu_exception_unit.sv | 155 +++++++++++++++
 tb/tb_alu_exception_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exception_unit.sv
// Exception unit for the ALU status interface: flags overflow, divide-by-zero and misalignment, latches cause/EPC, handshakes with control.
// Optional macro ALU_EXC_COUNT_EN adds a saturating exception counter output exc_count.
//
// state   | meaning
// IDLE    | watching execute-stage status for a qualifying fault
// PENDING | exception latched, exc_req/stall high, waiting for exc_ack
// FLUSH   | one-cycle flush pulse after ack, then back to IDLE
module alu_exception_unit #(
  parameter bit         CHECK_ALIGN = 1'b1,
  parameter logic [4:0] CAUSE_OVF   = 5'd12,
  parameter logic [4:0] CAUSE_DIVZ  = 5'd13,
  parameter logic [4:0] CAUSE_ALIGN = 5'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  alu_ctrl,
  input  logic [7:0]  alu_status,
  input  logic        trap_ovf_en,
  input  logic        exc_ack,
  input  logic        status_clr,
  output logic        exc_req,
  output logic [4:0]  exc_cause,
  output logic [31:0] epc,
  output logic        flush,
  output logic        stall,
  output logic [7:0]  sticky_flags
`ifdef ALU_EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  sticky_q, sticky_d;

  logic        divz_hit, ovf_hit, align_hit, fault;
  logic [4:0]  sel_cause;
  logic        unused_status;

  assign unused_status = ^alu_status[1:0];

  always_comb begin
    divz_hit  = ex_valid && (alu_ctrl == 4'b1001) && alu_status[2];
    ovf_hit   = ex_valid && trap_ovf_en && alu_status[6] &&
                ((alu_ctrl == 4'b0010) || (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b1000));
    align_hit = ex_valid && CHECK_ALIGN && alu_status[3];
    fault     = divz_hit || ovf_hit || align_hit;
    if (divz_hit)     sel_cause = CAUSE_DIVZ;
    else if (ovf_hit) sel_cause = CAUSE_OVF;
    else              sel_cause = CAUSE_ALIGN;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    stall_d = stall_q;
    flush_d = flush_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      IDLE: begin
        if (fault) begin
          state_d = PENDING;
          req_d   = 1'b1;
          stall_d = 1'b1;
          cause_d = sel_cause;
          epc_d   = ex_pc;
        end
      end
      PENDING: begin
        if (exc_ack) begin
          state_d = FLUSH;
          req_d   = 1'b0;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        flush_d = 1'b0;
        stall_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  // Clear takes effect first so a same-cycle accumulate leaves only this cycle's flags
  always_comb begin
    sticky_d = status_clr ? 6'd0 : sticky_q;
    if ((state_q == IDLE) && ex_valid)
      sticky_d = sticky_d | alu_status[7:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      stall_q  <= 1'b0;
      flush_q  <= 1'b0;
      cause_q  <= 5'd0;
      epc_q    <= 32'd0;
      sticky_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef ALU_EXC_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = status_clr ? 16'd0 : count_q;
    if ((state_q == IDLE) && fault && (count_d != 16'hFFFF))
      count_d = count_d + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign exc_count = count_q;
`endif

  assign exc_req      = req_q;
  assign stall        = stall_q;
  assign flush        = flush_q;
  assign exc_cause    = cause_q;
  assign epc          = epc_q;
  assign sticky_flags = {sticky_q, 2'b00};

endmodule

// File: tb/tb_alu_exception_unit.sv
// Self-checking bench for alu_exception_unit: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_alu_exception_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_status;
  logic        trap_ovf_en;
  logic        exc_ack;
  logic        status_clr;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] epc;
  logic        flush;
  logic        stall;
  logic [7:0]  sticky_flags;
`ifdef ALU_EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  int checks   = 0;
  int failures = 0;

  alu_exception_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .alu_ctrl     (alu_ctrl),
    .alu_status   (alu_status),
    .trap_ovf_en  (trap_ovf_en),
    .exc_ack      (exc_ack),
    .status_clr   (status_clr),
    .exc_req      (exc_req),
    .exc_cause    (exc_cause),
    .epc          (epc),
    .flush        (flush),
    .stall        (stall),
    .sticky_flags (sticky_flags)
`ifdef ALU_EXC_COUNT_EN
    ,
    .exc_count    (exc_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic [31:0] pc, input logic [3:0] ctrl,
                      input logic [7:0] st, input logic oe, input logic ack, input logic clr);
    ex_valid = v; ex_pc = pc; alu_ctrl = ctrl; alu_status = st;
    trap_ovf_en = oe; exc_ack = ack; status_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({exc_req, stall, flush, exc_cause, epc, sticky_flags} !== 48'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {exc_req, stall, flush, exc_cause, epc, sticky_flags});
    end
  endtask

  task automatic test_divz();
    step(1, 32'h0040_0010, 4'b1001, 8'h04, 0, 0, 0);
    checks++;
    if ({exc_req, stall, flush} !== 3'b110) begin
      failures++; $display("FAIL divz_req got=%b exp=110", {exc_req, stall, flush});
    end
    checks++;
    if (exc_cause !== 5'd13) begin
      failures++; $display("FAIL divz_cause got=%0d exp=13", exc_cause);
    end
    checks++;
    if (epc !== 32'h0040_0010) begin
      failures++; $display("FAIL divz_epc got=%h exp=00400010", epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({exc_req, stall, flush} !== 3'b011) begin
      failures++; $display("FAIL divz_flush got=%b exp=011", {exc_req, stall, flush});
    end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({exc_req, stall, flush, exc_cause, epc} !== {3'b000, 5'd13, 32'h0040_0010}) begin
      failures++; $display("FAIL divz_return got=%b/%0d/%h exp=000/13/00400010",
                           {exc_req, stall, flush}, exc_cause, epc);
    end
  endtask

  task automatic test_ovf_trap();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h100, 4'b0010, 8'h40, 0, 0, 0);
    checks++;
    if (exc_req !== 1'b0 || sticky_flags !== 8'h40) begin
      failures++; $display("FAIL ovf_masked got=req%b sticky%h exp=req0 sticky40", exc_req, sticky_flags);
    end
    step(1, 32'h104, 4'b0110, 8'h40, 1, 0, 0);
    checks++;
    if (exc_req !== 1'b1 || exc_cause !== 5'd12 || epc !== 32'h104) begin
      failures++; $display("FAIL ovf_trap got=req%b cause%0d epc%h exp=req1 cause12 epc104", exc_req, exc_cause, epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h108, 4'b0000, 8'h40, 1, 0, 0);
    checks++;
    if (exc_req !== 1'b0) begin
      failures++; $display("FAIL ovf_wrong_op got=%b exp=0", exc_req);
    end
  endtask

  task automatic test_priority_hold();
    step(1, 32'h200, 4'b1001, 8'h4C, 1, 0, 0);
    checks++;
    if (exc_cause !== 5'd13 || epc !== 32'h200) begin
      failures++; $display("FAIL prio_cause got=%0d/%h exp=13/00000200", exc_cause, epc);
    end
    step(1, 32'h14, 4'b0010, 8'h48, 1, 0, 0);
    checks++;
    if (exc_req !== 1'b1 || exc_cause !== 5'd13 || epc !== 32'h200) begin
      failures++; $display("FAIL hold_epc got=req%b cause%0d epc%h exp=req1 cause13 epc200", exc_req, exc_cause, epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h300, 4'b0000, 8'h08, 0, 0, 0);
    checks++;
    if (exc_cause !== 5'd4 || epc !== 32'h300) begin
      failures++; $display("FAIL align_cause got=%0d/%h exp=4/00000300", exc_cause, epc);
    end
    step(1, 32'h304, 4'b1000, 8'h48, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h308, 4'b1000, 8'h48, 1, 0, 0);
    checks++;
    if (exc_cause !== 5'd12 || epc !== 32'h308) begin
      failures++; $display("FAIL ovf_over_align got=%0d/%h exp=12/00000308", exc_cause, epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_sticky();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 4'b0000, 8'h80, 0, 0, 0);
    step(1, 0, 4'b0000, 8'h13, 0, 0, 0);
    checks++;
    if (sticky_flags !== 8'h90) begin
      failures++; $display("FAIL sticky_or got=%h exp=90", sticky_flags);
    end
    step(1, 0, 4'b0000, 8'h20, 0, 0, 1);
    checks++;
    if (sticky_flags !== 8'h20) begin
      failures++; $display("FAIL sticky_clr_set got=%h exp=20", sticky_flags);
    end
    step(1, 32'h400, 4'b1001, 8'h04, 0, 0, 0);
    step(1, 32'h404, 4'b0000, 8'h80, 0, 0, 0);
    checks++;
    if (sticky_flags !== 8'h24) begin
      failures++; $display("FAIL sticky_pending got=%h exp=24", sticky_flags);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (sticky_flags !== 8'h00) begin
      failures++; $display("FAIL sticky_clr got=%h exp=00", sticky_flags);
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    step(1, 32'hA0, 4'b1001, 8'h04, 0, 1, 0);
    step(1, 32'hB0, 4'b1001, 8'h04, 0, 0, 0);
    checks++;
    if (exc_req !== 1'b1 || epc !== 32'hA0) begin
      failures++; $display("FAIL b2b_capture got=req%b epc%h exp=req1 epcA0", exc_req, epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({exc_req, stall, flush} !== 3'b000 || epc !== 32'hA0) begin
      failures++; $display("FAIL b2b_dropped got=%b epc%h exp=000 epcA0", {exc_req, stall, flush}, epc);
    end
  endtask

  task automatic test_reset_mid_pending();
    step(1, 32'h500, 4'b1001, 8'h84, 0, 0, 0);
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({exc_req, stall, flush, exc_cause, epc, sticky_flags} !== 48'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", {exc_req, stall, flush, exc_cause, epc, sticky_flags});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h504, 4'b0000, 8'h08, 0, 0, 0);
    checks++;
    if (exc_req !== 1'b1 || epc !== 32'h504) begin
      failures++; $display("FAIL reset_idle got=req%b epc%h exp=req1 epc504", exc_req, epc);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef ALU_EXC_COUNT_EN
  task automatic test_count();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h600 + i, 4'b1001, 8'h04, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (exc_count !== 16'd3) begin
      failures++; $display("FAIL count_three got=%0d exp=3", exc_count);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (exc_count !== 16'd0) begin
      failures++; $display("FAIL count_clr got=%0d exp=0", exc_count);
    end
    step(1, 32'h700, 4'b1001, 8'h04, 0, 0, 1);
    checks++;
    if (exc_count !== 16'd1) begin
      failures++; $display("FAIL count_clr_inc got=%0d exp=1", exc_count);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
`endif

  // Reference model: the unit is either free, holding one exception, or flushing
  task automatic test_random();
    int          mode;
    logic [4:0]  m_cause;
    logic [31:0] m_epc;
    logic [7:0]  m_sticky;
    logic        v, oe, ack, clr, hit;
    logic [3:0]  ctrl;
    logic [7:0]  st;
    logic [31:0] pc;
    logic [4:0]  code;
    logic [3:0]  ops [5];
    logic [47:0] got, exp;
    ops[0] = 4'b1001; ops[1] = 4'b0010; ops[2] = 4'b0110; ops[3] = 4'b1000; ops[4] = 4'b0000;
    do_reset();
    mode = 0; m_cause = 0; m_epc = 0; m_sticky = 0;
    for (int n = 0; n < 600; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      ctrl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
      st   = 8'($urandom) & (($urandom_range(0, 1) == 1) ? 8'hF3 : 8'hFF);
      pc   = $urandom;
      oe   = 1'($urandom);
      ack  = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 9) == 0);

      hit = 1'b1;
      if (v && ctrl == 4'd9 && st[2]) code = 5'd13;
      else if (v && oe && st[6] && (ctrl == 4'd2 || ctrl == 4'd6 || ctrl == 4'd8)) code = 5'd12;
      else if (v && st[3]) code = 5'd4;
      else begin code = 5'd0; hit = 1'b0; end

      m_sticky = clr ? 8'h00 : m_sticky;
      if (mode == 0 && v) m_sticky = m_sticky | (st & 8'hFC);
      if (mode == 0) begin
        if (hit) begin mode = 1; m_cause = code; m_epc = pc; end
      end else if (mode == 1) begin
        if (ack) mode = 2;
      end else mode = 0;

      step(v, pc, ctrl, st, oe, ack, clr);
      exp = {(mode == 1), (mode != 0), (mode == 2), m_cause, m_epc, m_sticky};
      got = {exc_req, stall, flush, exc_cause, epc, sticky_flags};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_pc = 0; alu_ctrl = 0; alu_status = 0;
    trap_ovf_en = 0; exc_ack = 0; status_clr = 0;
    test_reset();
    test_divz();
    test_ovf_trap();
    test_priority_hold();
    test_sticky();
    test_back_to_back();
    test_reset_mid_pending();
`ifdef ALU_EXC_COUNT_EN
    test_count();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
